// File: rtl/mainfsm_pkg.sv
// Shared controller definitions: state encodings, datapath select codes, Op classes.
// Pure declarations; no timing.
// No flow control; constants only.
package mainfsm_pkg;

  localparam int STATE_W = 4;

  // Main FSM states; encodings 11..15 are unused and recover to FETCH.
  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  // ALU A-operand select
  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Instruction class, from instruction bits [27:26]
  localparam logic [1:0] OP_DP       = 2'b00;
  localparam logic [1:0] OP_MEM      = 2'b01;
  localparam logic [1:0] OP_BR       = 2'b10;
  localparam logic [1:0] OP_ILL      = 2'b11;

endpackage

// File: rtl/mainfsm_outdec.sv
// State-to-control-word decoder for the main FSM (Moore outputs).
// Purely combinational, zero cycles.
// No flow control; every unlisted output is driven 0.
module mainfsm_outdec
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] i_state,
  output logic               o_irwrite,
  output logic               o_adrsrc,
  output logic [1:0]         o_alusrca,
  output logic [1:0]         o_alusrcb,
  output logic [1:0]         o_resultsrc,
  output logic               o_aluop,
  output logic               o_nextpc,
  output logic               o_regw,
  output logic               o_memw,
  output logic               o_branch
);

  // Decode the current state into datapath controls; all-zero is the safe default.
  always_comb begin
    o_irwrite   = 1'b0;
    o_adrsrc    = 1'b0;
    o_alusrca   = 2'b00;
    o_alusrcb   = 2'b00;
    o_resultsrc = 2'b00;
    o_aluop     = 1'b0;
    o_nextpc    = 1'b0;
    o_regw      = 1'b0;
    o_memw      = 1'b0;
    o_branch    = 1'b0;
    case (state_t'(i_state))
      FETCH: begin
        o_irwrite   = 1'b1;
        o_adrsrc    = 1'b0;
        o_alusrca   = SRCA_PC;
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALU;
        o_aluop     = 1'b0;
        o_nextpc    = 1'b1;
      end
      DECODE: begin
        o_alusrca   = SRCA_PC;
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALU;
      end
      MEMADR: begin
        o_alusrca   = SRCA_REG;
        o_alusrcb   = SRCB_IMM;
      end
      MEMRD: begin
        o_adrsrc    = 1'b1;
        o_resultsrc = RES_ALUOUT;
      end
      MEMWB: begin
        o_resultsrc = RES_DATA;
        o_regw      = 1'b1;
      end
      MEMWR: begin
        o_adrsrc    = 1'b1;
        o_resultsrc = RES_ALUOUT;
        o_memw      = 1'b1;
      end
      EXECUTER: begin
        o_alusrca   = SRCA_REG;
        o_alusrcb   = SRCB_REG;
        o_aluop     = 1'b1;
      end
      EXECUTEI: begin
        o_alusrca   = SRCA_REG;
        o_alusrcb   = SRCB_IMM;
        o_aluop     = 1'b1;
      end
      ALUWB: begin
        o_resultsrc = RES_ALUOUT;
        o_regw      = 1'b1;
      end
      BRANCH: begin
        o_alusrca   = SRCA_ALUOUT;
        o_alusrcb   = SRCB_IMM;
        o_resultsrc = RES_ALU;
        o_branch    = 1'b1;
      end
      default: ;  // UNKNOWN and unused encodings: no side effects
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Outputs are a Moore decode of the state register; 3 to 5 cycles per instruction.
// No flow control; advances one state per clock, reset returns to FETCH.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic [STATE_W-1:0] State
);

  logic [STATE_W-1:0] r_state;
  state_t             w_next;
  logic               w_unused_funct;

  // Only I (bit 5) and L (bit 0) steer the sequence; the rest belong to the decoder.
  assign w_unused_funct = ^Funct[4:1];

  // State register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STATE_W'(FETCH);
    end else begin
      r_state <= STATE_W'(w_next);
    end
  end

  // Next-state logic; Op/Funct only matter in DECODE and MEMADR.
  always_comb begin
    w_next = FETCH;
    case (state_t'(r_state))
      FETCH:    w_next = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  w_next = MEMADR;
          OP_DP:   w_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   w_next = BRANCH;
          default: w_next = UNKNOWN;
        endcase
      end
      MEMADR:   w_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    w_next = MEMWB;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      default:  w_next = FETCH;  // MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN, unused
    endcase
  end

  assign State = r_state;

  mainfsm_outdec #(
    .STATE_W (STATE_W)
  ) u_outdec (
    .i_state     (r_state),
    .o_irwrite   (IRWrite),
    .o_adrsrc    (AdrSrc),
    .o_alusrca   (ALUSrcA),
    .o_alusrcb   (ALUSrcB),
    .o_resultsrc (ResultSrc),
    .o_aluop     (ALUOp),
    .o_nextpc    (NextPC),
    .o_regw      (RegW),
    .o_memw      (MemW),
    .o_branch    (Branch)
  );

endmodule
